// File: rtl/sddac_cic_decim.sv
// Third-order CIC decimator that turns the 1-bit sigma-delta stream back into
// signed PCM at 1/R of the bit rate. Integrators run at the bit rate and combs
// run once per decimation event. All accumulator arithmetic wraps on purpose,
// because the comb differences cancel the wrap exactly.
module sddac_cic_decim #(
  parameter int unsigned ORDER = 3,
  parameter int unsigned LOG2R = 6,
  parameter int unsigned OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    bit_in,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int unsigned ACC_W  = 2 + ORDER * LOG2R;
  localparam int unsigned SHIFT  = ORDER * LOG2R - (OUT_W - 1);
  localparam int unsigned WU_MAX = ORDER + 1;
  localparam int unsigned WU_W   = $clog2(WU_MAX + 1);

  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(2 ** (OUT_W - 1) - 1);
  // Bitwise inverse of 2^(W-1)-1 is -2^(W-1) in two's complement.
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  // The output shift would go negative if the filter gain cannot fill OUT_W.
  if (ORDER * LOG2R < OUT_W - 1) begin : g_width_check
    $error("sddac_cic_decim: ORDER*LOG2R must be at least OUT_W-1");
  end

  logic signed [ACC_W-1:0] integ_q [ORDER];
  logic signed [ACC_W-1:0] integ_d [ORDER];
  logic signed [ACC_W-1:0] dly_q   [ORDER];
  logic signed [ACC_W-1:0] dly_d   [ORDER];
  logic signed [ACC_W-1:0] comb    [ORDER];
  logic        [LOG2R-1:0] cnt_q, cnt_d;
  logic        [WU_W-1:0]  wu_q, wu_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    valid_q, valid_d;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] scaled;
  logic signed [OUT_W-1:0] sat;
  logic                    dec_evt;
  logic                    warm;

  assign dec_evt = en && (cnt_q == '1);
  assign warm    = (wu_q == WU_W'(WU_MAX));

  // Integrator chain; each stage sums the pre-edge value of the stage before it.
  always_comb begin
    x = bit_in ? ACC_W'(1) : '1;
    integ_d[0] = integ_q[0] + x;
    for (int j = 1; j < ORDER; j++) begin
      integ_d[j] = integ_q[j] + integ_q[j-1];
    end
  end

  // Comb chain on the registered last integrator, plus the delay-line update.
  always_comb begin
    comb[0]  = integ_q[ORDER-1] - dly_q[0];
    dly_d[0] = integ_q[ORDER-1];
    for (int j = 1; j < ORDER; j++) begin
      comb[j]  = comb[j-1] - dly_q[j];
      dly_d[j] = comb[j-1];
    end
  end

  // Scale down to OUT_W and saturate; only the full-scale positive peak clips.
  always_comb begin
    scaled = comb[ORDER-1] >>> SHIFT;
    if (scaled > SatMax) begin
      sat = OUT_W'(SatMax);
    end else if (scaled < SatMin) begin
      sat = OUT_W'(SatMin);
    end else begin
      sat = OUT_W'(scaled);
    end
  end

  // Counter, warm-up and output next-state.
  always_comb begin
    cnt_d   = cnt_q;
    wu_d    = wu_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (en) begin
      cnt_d = cnt_q + LOG2R'(1);
    end
    if (dec_evt) begin
      dout_d  = sat;
      valid_d = warm;
      if (!warm) begin
        wu_d = wu_q + WU_W'(1);
      end
    end
  end

  // State registers with synchronous reset; rst overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      cnt_q   <= '0;
      wu_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (en) begin
        integ_q <= integ_d;
      end
      if (dec_evt) begin
        dly_q <= dly_d;
      end
      cnt_q   <= cnt_d;
      wu_q    <= wu_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: doc/sddac_cic_decim.md
Name: sddac_cic_decim

Overview:
- Third-order CIC decimator that consumes the 1-bit stream produced by the sigma-delta DAC modulator.
- Converts that stream back to signed 16-bit PCM at 1/R of the bit rate.
- Sits directly downstream of sddac, so the bench and loopback tests can check the modulator against its own input.
- Implemented as integrators at the bit rate, a decimation counter, and combs at the output rate.

Parameters:
- ORDER, 3: number of integrator and comb stages; fixed at 3 for this revision.
- LOG2R, 6: log2 of the decimation ratio; R = 2^LOG2R = 64.
- OUT_W, 16: output word width.
- ACC_W, 2+ORDER*LOG2R = 20: internal accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock; same clock as sddac.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  bit_in is valid this cycle; tie to 1 when following sddac directly.
- bit_in  in  1  modulator output; 1 maps to +1, 0 maps to -1.
- dout  out  OUT_W  signed decimated sample.
- dout_valid  out  1  single-cycle strobe; dout is valid in the same cycle.

Behaviour:
- Reset (rst high at a clk edge) clears all of the following to 0: integrators i1..i3, comb delays d1..d3, decimation counter cnt, warm-up counter wu, dout, dout_valid.
- Reset applied mid-operation discards all state and restarts warm-up.
- Input mapping: x = bit_in ? +1 : -1, sign-extended to ACC_W.
- Integrators (update only when en=1; hold when en=0), using pre-edge values on the right-hand side:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - All additions are ACC_W-bit two's complement with wrap-around; no saturation.
  - Wrap is intentional; the comb stages cancel it exactly.
- Decimation counter cnt (LOG2R bits):
  - Increments on en=1 and wraps R-1 -> 0.
  - A decimation event occurs on an en=1 cycle with cnt == R-1.
- Comb stages, evaluated combinationally on the decimation event using the current registered i3:
  - c1 = i3 - d1
  - c2 = c1 - d2
  - c3 = c2 - d3
  - Delays update on the same edge: d1 <= i3, d2 <= c1, d3 <= c2. ACC_W wrap arithmetic.
- Output scaling:
  - y = c3, with ideal range [-2^18, +2^18].
  - s = y >>> (ORDER*LOG2R - (OUT_W-1)), i.e. an arithmetic shift by 3.
  - Saturate s to [-32768, 32767]; only +32768 actually clips.
- Output register:
  - dout is loaded with the saturated s on the decimation event edge.
  - dout_valid is high for exactly the next cycle.
  - dout holds its value between events.
- Latency: dout_valid rises 1 clk after the en cycle that carries the R-th bit of a frame.
- Warm-up:
  - The first ORDER+1 = 4 decimation events after reset still update dout and the comb delays.
  - dout_valid stays low for those 4 events.
  - wu saturates at 4.
- en=0 cycles freeze all state; dout_valid=0 in any cycle not following an event.
- Simultaneous rst and en: rst wins.
- Static elaboration check: error if ORDER*LOG2R < OUT_W-1.

Test Plan:
- All-ones: rst for 2 clks, then en=1, bit_in=1 for 64*10 clks -> exactly 10 decimation events, with the first valid on the 5th. Every valid dout = 32767 (clipped), strobes exactly 64 clks apart.
- All-zeros: same sequence with bit_in=0 -> every valid dout = -32768 exactly.
- Alternating 1,0,1,0...: same sequence -> every valid dout = 0 exactly (Nyquist null, R even).
- en gating: 1/4 density pattern (1,0,0,0 repeat) with en toggling 1,0 every cycle -> strobes 128 clks apart. Every valid dout = -16384. State is unchanged across en=0 cycles; a check on i1 during en=0 cycles shows no change.
- Reset mid-stream: assert rst for 1 clk at cnt=37 during the all-ones run -> next cycle all outputs 0. The next valid strobe comes after 5*64 en cycles.
- Loopback: feed sddac with a 16-bit sine at amplitude 10000 and 0.001 cycles/clk, running 2^18 clks. Chain sddac -> this block with en=1 -> after warm-up, decimated peaks are 10000 +/- 200 LSB. The zero-mean residual after sine fit is below 100 LSB RMS.
